// File: rtl/uart_axil_responder_if.sv
// AXI4-Lite channel bundle between the system master and the UART responder (13-bit address, 32-bit data).
// The master modport drives requests, and the slave modport drives ready and response signals.
interface uart_axil_responder_if;
  logic [12:0] uart_axi_awaddr;
  logic        uart_axi_awvalid;
  logic        uart_axi_awready;
  logic [31:0] uart_axi_wdata;
  logic [3:0]  uart_axi_wstrb;
  logic        uart_axi_wvalid;
  logic        uart_axi_wready;
  logic [1:0]  uart_axi_bresp;
  logic        uart_axi_bvalid;
  logic        uart_axi_bready;
  logic [12:0] uart_axi_araddr;
  logic        uart_axi_arvalid;
  logic        uart_axi_arready;
  logic [31:0] uart_axi_rdata;
  logic [1:0]  uart_axi_rresp;
  logic        uart_axi_rvalid;
  logic        uart_axi_rready;

  modport master (
    output uart_axi_awaddr, uart_axi_awvalid, uart_axi_wdata, uart_axi_wstrb, uart_axi_wvalid,
           uart_axi_bready, uart_axi_araddr, uart_axi_arvalid, uart_axi_rready,
    input  uart_axi_awready, uart_axi_wready, uart_axi_bresp, uart_axi_bvalid,
           uart_axi_arready, uart_axi_rdata, uart_axi_rresp, uart_axi_rvalid
  );

  modport slave (
    input  uart_axi_awaddr, uart_axi_awvalid, uart_axi_wdata, uart_axi_wstrb, uart_axi_wvalid,
           uart_axi_bready, uart_axi_araddr, uart_axi_arvalid, uart_axi_rready,
    output uart_axi_awready, uart_axi_wready, uart_axi_bresp, uart_axi_bvalid,
           uart_axi_arready, uart_axi_rdata, uart_axi_rresp, uart_axi_rvalid
  );
endinterface

// File: rtl/uart_axil_responder.sv
// AXI4-Lite UART register block with TX/RX byte FIFOs; optional internal loopback under UART_AXIL_LOOPBACK_EN.
// B/R respond one cycle after accept with one outstanding each; TX waits on tx_ready, RX drops bytes when full.

// Byte FIFO with flush: a push to a full FIFO is dropped, a pop from an empty FIFO is ignored, and flush overrides both.
// The head byte is read straight from registered storage, so it is valid in the cycle after the push.
module uart_axil_byte_fifo #(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [7:0]       push_dat,
  input  logic             pop,
  input  logic             flush,
  output logic [7:0]       head_dat,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end
endmodule

module uart_axil_responder #(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  chipset_clk,
  input  logic                  chipset_rst_n,
  uart_axil_responder_if.slave  axi,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  uart_irq
);
  localparam logic [10:0] A_RXDATA = 11'h000;
  localparam logic [10:0] A_TXDATA = 11'h001;
  localparam logic [10:0] A_STATUS = 11'h002;
  localparam logic [10:0] A_CTRL   = 11'h003;

  logic             run_q;
  logic             bvalid_q, rvalid_q;
  logic [1:0]       bresp_q, rresp_q;
  logic [31:0]      rdata_q;
  logic             rx_irq_en_q, txe_irq_en_q;
  logic             tx_ovf_q, rx_ovr_q;
  logic             irq_q;

  logic [10:0]      waddr, raddr;
  logic             wr_hs, rd_hs;
  logic             ctrl_wr, tx_wr;
  logic             tx_flush, rx_flush, sticky_clr;
  logic             tx_ovf_set, rx_ovr_set;
  logic             wr_err;
  logic             lb_rd;

  logic             tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]       tx_head;
  logic [CNT_W-1:0] tx_count;
  logic             rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]       rx_push_dat, rx_head;
  logic [CNT_W-1:0] rx_count;

  logic [31:0]      status;
  logic [31:0]      rd_dat_c;
  logic             rd_err_c;

  logic             unused_ok;
  assign unused_ok = ^{axi.uart_axi_awaddr[1:0], axi.uart_axi_araddr[1:0],
                       axi.uart_axi_wdata[31:8], axi.uart_axi_wstrb[3:1]};

  // run_q keeps every ready low while reset is asserted and for the first cycle after release.
  assign waddr = axi.uart_axi_awaddr[12:2];
  assign raddr = axi.uart_axi_araddr[12:2];
  assign wr_hs = run_q & axi.uart_axi_awvalid & axi.uart_axi_wvalid & ~bvalid_q;
  assign rd_hs = axi.uart_axi_arvalid & axi.uart_axi_arready;

  assign axi.uart_axi_awready = wr_hs;
  assign axi.uart_axi_wready  = wr_hs;
  assign axi.uart_axi_arready = run_q & ~rvalid_q;
  assign axi.uart_axi_bvalid  = bvalid_q;
  assign axi.uart_axi_bresp   = bresp_q;
  assign axi.uart_axi_rvalid  = rvalid_q;
  assign axi.uart_axi_rresp   = rresp_q;
  assign axi.uart_axi_rdata   = rdata_q;
  assign uart_irq             = irq_q;
  assign tx_data              = tx_head;

  assign ctrl_wr    = wr_hs & (waddr == A_CTRL) & axi.uart_axi_wstrb[0];
  assign tx_wr      = wr_hs & (waddr == A_TXDATA) & axi.uart_axi_wstrb[0];
  assign tx_flush   = ctrl_wr & axi.uart_axi_wdata[2];
  assign rx_flush   = ctrl_wr & axi.uart_axi_wdata[3];
  assign sticky_clr = ctrl_wr & axi.uart_axi_wdata[4];
  assign tx_push    = tx_wr;

  assign tx_ovf_set = tx_wr & tx_full & ~tx_flush;
  assign rx_ovr_set = rx_push & rx_full & ~rx_flush;

`ifdef UART_AXIL_LOOPBACK_EN
  logic lb_q;
  logic lb_move;

  // In loopback the TX head moves into RX whenever RX has room, so RX cannot overrun.
  assign lb_move     = lb_q & ~tx_empty & ~rx_full;
  assign tx_valid    = ~tx_empty & ~lb_q;
  assign tx_pop      = lb_move | (tx_valid & tx_ready);
  assign rx_push     = lb_q ? lb_move : rx_valid;
  assign rx_push_dat = lb_q ? tx_head : rx_data;
  assign lb_rd       = lb_q;

  always_ff @(posedge chipset_clk or negedge chipset_rst_n) begin
    if (!chipset_rst_n)  lb_q <= 1'b0;
    else if (ctrl_wr)    lb_q <= axi.uart_axi_wdata[5];
  end
`else
  assign tx_valid    = ~tx_empty;
  assign tx_pop      = tx_valid & tx_ready;
  assign rx_push     = rx_valid;
  assign rx_push_dat = rx_data;
  assign lb_rd       = 1'b0;
`endif

  uart_axil_byte_fifo #(.DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_tx_fifo (
    .clk(chipset_clk), .rst_n(chipset_rst_n),
    .push(tx_push), .push_dat(axi.uart_axi_wdata[7:0]), .pop(tx_pop), .flush(tx_flush),
    .head_dat(tx_head), .count(tx_count), .full(tx_full), .empty(tx_empty)
  );

  uart_axil_byte_fifo #(.DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_rx_fifo (
    .clk(chipset_clk), .rst_n(chipset_rst_n),
    .push(rx_push), .push_dat(rx_push_dat), .pop(rx_pop), .flush(rx_flush),
    .head_dat(rx_head), .count(rx_count), .full(rx_full), .empty(rx_empty)
  );

  assign status = {8'd0, 8'(tx_count), 8'(rx_count), 2'b00,
                   rx_ovr_q, tx_ovf_q, tx_full, tx_empty, rx_full, ~rx_empty};

  always_comb begin
    wr_err = 1'b1;
    case (waddr)
      A_TXDATA: wr_err = axi.uart_axi_wstrb[0] & tx_full;
      A_CTRL:   wr_err = 1'b0;
      default:  wr_err = 1'b1;
    endcase
  end

  // An RXDATA read pops only when it is accepted and the FIFO holds a byte.
  always_comb begin
    rd_dat_c = '0;
    rd_err_c = 1'b0;
    rx_pop   = 1'b0;
    case (raddr)
      A_RXDATA: begin
        if (!rx_empty) begin
          rx_pop   = rd_hs;
          rd_dat_c = {1'b1, 23'd0, rx_head};
        end
      end
      A_STATUS: rd_dat_c = status;
      A_CTRL:   rd_dat_c = {26'd0, lb_rd, 3'b000, txe_irq_en_q, rx_irq_en_q};
      default:  rd_err_c = 1'b1;
    endcase
  end

  always_ff @(posedge chipset_clk or negedge chipset_rst_n) begin
    if (!chipset_rst_n) begin
      run_q        <= 1'b0;
      bvalid_q     <= 1'b0;
      bresp_q      <= 2'b00;
      rvalid_q     <= 1'b0;
      rresp_q      <= 2'b00;
      rdata_q      <= '0;
      rx_irq_en_q  <= 1'b0;
      txe_irq_en_q <= 1'b0;
      tx_ovf_q     <= 1'b0;
      rx_ovr_q     <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      run_q <= 1'b1;

      if (wr_hs) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_err ? 2'b10 : 2'b00;
      end else if (axi.uart_axi_bready) begin
        bvalid_q <= 1'b0;
      end

      if (rd_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_dat_c;
        rresp_q  <= rd_err_c ? 2'b10 : 2'b00;
      end else if (axi.uart_axi_rready) begin
        rvalid_q <= 1'b0;
      end

      if (ctrl_wr) begin
        rx_irq_en_q  <= axi.uart_axi_wdata[0];
        txe_irq_en_q <= axi.uart_axi_wdata[1];
      end

      // A clear wins over a set in the same cycle.
      if (sticky_clr) begin
        tx_ovf_q <= 1'b0;
        rx_ovr_q <= 1'b0;
      end else begin
        if (tx_ovf_set) tx_ovf_q <= 1'b1;
        if (rx_ovr_set) rx_ovr_q <= 1'b1;
      end

      irq_q <= (rx_irq_en_q & (~rx_empty | rx_ovr_q)) | (txe_irq_en_q & tx_empty);
    end
  end
endmodule

// File: tb/tb_uart_axil_responder.sv
// Randomized scenario bench for uart_axil_responder: a queue-based model of both FIFOs and the sticky bits sets every expected value.
module tb_uart_axil_responder;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       uart_irq;

  always #5 clk = ~clk;

  uart_axil_responder_if bus ();

  uart_axil_responder #(.FIFO_DEPTH(DEPTH)) dut (
    .chipset_clk(clk), .chipset_rst_n(rst_n), .axi(bus),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .uart_irq(uart_irq)
  );

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  bit         m_tx_ovf, m_rx_ovr;

  function automatic logic [31:0] exp_status();
    int t = txq.size();
    int r = rxq.size();
    return {8'd0, 8'(t), 8'(r), 2'b00, m_rx_ovr, m_tx_ovf, t == DEPTH, t == 0, r == DEPTH, r != 0};
  endfunction

  task automatic axi_write(input logic [12:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    int n = 0;
    bus.uart_axi_awaddr = a; bus.uart_axi_wdata = d; bus.uart_axi_wstrb = s;
    bus.uart_axi_awvalid = 1'b1; bus.uart_axi_wvalid = 1'b1;
    @(negedge clk);
    while (!bus.uart_axi_awready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    bus.uart_axi_awvalid = 1'b0; bus.uart_axi_wvalid = 1'b0;
    n = 0;
    while (!bus.uart_axi_bvalid && n < 50) begin @(posedge clk); #1; n++; end
    resp = bus.uart_axi_bresp;
    if (!bus.uart_axi_bvalid) begin
      n_chk++; n_fail++;
      $display("FAIL write_timeout addr=%h: no bvalid, required bvalid=1", a);
      resp = 2'bxx;
    end
    bus.uart_axi_bready = 1'b1;
    @(posedge clk); #1;
    bus.uart_axi_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [12:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n = 0;
    bus.uart_axi_araddr = a; bus.uart_axi_arvalid = 1'b1;
    @(negedge clk);
    while (!bus.uart_axi_arready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    bus.uart_axi_arvalid = 1'b0;
    n = 0;
    while (!bus.uart_axi_rvalid && n < 50) begin @(posedge clk); #1; n++; end
    d = bus.uart_axi_rdata; resp = bus.uart_axi_rresp;
    if (!bus.uart_axi_rvalid) begin
      n_chk++; n_fail++;
      $display("FAIL read_timeout addr=%h: no rvalid, required rvalid=1", a);
      d = 'x; resp = 2'bxx;
    end
    bus.uart_axi_rready = 1'b1;
    @(posedge clk); #1;
    bus.uart_axi_rready = 1'b0;
  endtask

  task automatic rx_pulse(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    if (rxq.size() < DEPTH) rxq.push_back(b); else m_rx_ovr = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic [1:0] r;
    repeat (3) @(posedge clk); #1;
    n_chk++;
    if ({bus.uart_axi_awready, bus.uart_axi_wready, bus.uart_axi_bvalid, bus.uart_axi_arready,
         bus.uart_axi_rvalid} !== 5'b0) begin
      n_fail++; $display("FAIL reset_hs: got %b required 00000", {bus.uart_axi_awready,
        bus.uart_axi_wready, bus.uart_axi_bvalid, bus.uart_axi_arready, bus.uart_axi_rvalid});
    end
    n_chk++;
    if ({bus.uart_axi_bresp, bus.uart_axi_rresp, bus.uart_axi_rdata} !== 36'd0) begin
      n_fail++; $display("FAIL reset_resp: got %h required 0",
        {bus.uart_axi_bresp, bus.uart_axi_rresp, bus.uart_axi_rdata});
    end
    n_chk++;
    if ({tx_valid, uart_irq} !== 2'b00) begin
      n_fail++; $display("FAIL reset_tx_irq: got %b required 00", {tx_valid, uart_irq});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    axi_read(13'h008, d, r);
    n_chk++;
    if (d !== 32'h0000_0004 || r !== 2'b00) begin
      n_fail++; $display("FAIL reset_status: got %h/%b required 00000004/00", d, r);
    end
    n_chk++;
    if (uart_irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b required 0", uart_irq); end
  endtask

  task automatic test_tx_order();
    logic [31:0] d; logic [1:0] r;
    axi_write(13'h004, 32'h41, 4'hF, r); txq.push_back(8'h41);
    axi_write(13'h004, 32'h42, 4'hF, r); txq.push_back(8'h42);
    axi_read(13'h008, d, r);
    n_chk++;
    if (d[23:16] !== 8'd2) begin n_fail++; $display("FAIL tx_count_2: got %0d required 2", d[23:16]); end
    tx_ready = 1'b1;
    n_chk++;
    if ({tx_valid, tx_data} !== {1'b1, txq.pop_front()}) begin
      n_fail++; $display("FAIL tx_first: got %b/%h required 1/41", tx_valid, tx_data);
    end
    @(posedge clk); #1;
    n_chk++;
    if ({tx_valid, tx_data} !== {1'b1, txq.pop_front()}) begin
      n_fail++; $display("FAIL tx_second: got %b/%h required 1/42", tx_valid, tx_data);
    end
    @(posedge clk); #1;
    tx_ready = 1'b0;
    n_chk++;
    if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL tx_drained: tx_valid got %b required 0", tx_valid); end
    axi_read(13'h008, d, r);
    n_chk++;
    if (d !== exp_status()) begin n_fail++; $display("FAIL tx_status_0: got %h required %h", d, exp_status()); end
  endtask

  task automatic test_tx_overflow();
    logic [31:0] d; logic [1:0] r; logic [7:0] b; logic [1:0] er; int cyc;
    for (int i = 0; i <= DEPTH; i++) begin
      b = 8'($urandom);
      axi_write(13'h004, {24'($urandom), b}, 4'hF, r);
      if (txq.size() < DEPTH) begin txq.push_back(b); er = 2'b00; end
      else begin m_tx_ovf = 1'b1; er = 2'b10; end
      n_chk++;
      if (r !== er) begin n_fail++; $display("FAIL tx_push_bresp[%0d]: got %b required %b", i, r, er); end
    end
    axi_read(13'h008, d, r);
    n_chk++;
    if (d !== exp_status()) begin n_fail++; $display("FAIL tx_ovf_status: got %h required %h", d, exp_status()); end
    axi_write(13'h00C, 32'h10, 4'hF, r); m_tx_ovf = 1'b0;
    axi_read(13'h008, d, r);
    n_chk++;
    if (d !== exp_status()) begin n_fail++; $display("FAIL tx_ovf_clear: got %h required %h", d, exp_status()); end
    cyc = 0;
    while ((txq.size() != 0 || tx_valid) && cyc < 500) begin
      tx_ready = 1'($urandom);
      if (tx_valid && tx_ready) begin
        n_chk++;
        if (txq.size() == 0 || tx_data !== txq[0]) begin
          n_fail++; $display("FAIL tx_drain_data: got %h required %h", tx_data, txq.size() ? txq[0] : 8'h00);
        end
        if (txq.size() != 0) void'(txq.pop_front());
      end
      @(posedge clk); #1; cyc++;
    end
    tx_ready = 1'b0;
    n_chk++;
    if (txq.size() != 0) begin n_fail++; $display("FAIL tx_drain_timeout: left %0d required 0", txq.size()); end
  endtask

  task automatic test_rx_irq();
    logic [31:0] d; logic [1:0] r;
    axi_write(13'h00C, 32'h1, 4'hF, r);
    rx_pulse(8'h5A);
    n_chk++;
    if (uart_irq !== 1'b0) begin n_fail++; $display("FAIL irq_early: got %b required 0", uart_irq); end
    @(posedge clk); #1;
    n_chk++;
    if (uart_irq !== 1'b1) begin n_fail++; $display("FAIL irq_rise: got %b required 1", uart_irq); end
    axi_read(13'h000, d, r); void'(rxq.pop_front());
    n_chk++;
    if (d !== 32'h8000_005A || r !== 2'b00) begin n_fail++; $display("FAIL rxdata_5a: got %h/%b required 8000005a/00", d, r); end
    n_chk++;
    if (uart_irq !== 1'b0) begin n_fail++; $display("FAIL irq_fall: got %b required 0", uart_irq); end
    axi_read(13'h000, d, r);
    n_chk++;
    if (d !== 32'h0 || r !== 2'b00) begin n_fail++; $display("FAIL rxdata_empty: got %h/%b required 0/00", d, r); end
    axi_write(13'h00C, 32'h0, 4'hF, r);
  endtask

  task automatic test_rx_random();
    logic [31:0] d; logic [1:0] r; int n;
    n = $urandom_range(3, DEPTH - 2);
    for (int i = 0; i < n; i++) begin
      rx_pulse(8'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    axi_read(13'h008, d, r);
    n_chk++;
    if (d !== exp_status()) begin n_fail++; $display("FAIL rx_rand_status: got %h required %h", d, exp_status()); end
    while (rxq.size() != 0) begin
      axi_read(13'h000, d, r);
      n_chk++;
      if (d !== {1'b1, 23'd0, rxq[0]}) begin n_fail++; $display("FAIL rx_rand_data: got %h required %h", d, {1'b1, 23'd0, rxq[0]}); end
      void'(rxq.pop_front());
    end
  endtask

  task automatic test_rx_overrun();
    logic [31:0] d; logic [1:0] r; logic [31:0] exp_d; bit stable;
    for (int i = 0; i < DEPTH; i++) rx_pulse(8'($urandom));
    axi_read(13'h008, d, r);
    n_chk++;
    if (d !== exp_status()) begin n_fail++; $display("FAIL rx_full_status: got %h required %h", d, exp_status()); end
    bus.uart_axi_araddr = 13'h000; bus.uart_axi_arvalid = 1'b1;
    rx_data = 8'($urandom); rx_valid = 1'b1;
    @(posedge clk); #1;
    bus.uart_axi_arvalid = 1'b0; rx_valid = 1'b0;
    exp_d = {1'b1, 23'd0, rxq.pop_front()};
    m_rx_ovr = 1'b1;
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (bus.uart_axi_rvalid !== 1'b1 || bus.uart_axi_rdata !== exp_d || bus.uart_axi_arready !== 1'b0) stable = 1'b0;
      @(posedge clk); #1;
    end
    n_chk++;
    if (!stable) begin n_fail++; $display("FAIL r_hold: rdata %h rvalid %b arready %b, required %h/1/0",
      bus.uart_axi_rdata, bus.uart_axi_rvalid, bus.uart_axi_arready, exp_d); end
    bus.uart_axi_rready = 1'b1;
    @(posedge clk); #1;
    bus.uart_axi_rready = 1'b0;
    n_chk++;
    if (bus.uart_axi_rvalid !== 1'b0) begin n_fail++; $display("FAIL r_release: rvalid got %b required 0", bus.uart_axi_rvalid); end
    axi_read(13'h008, d, r);
    n_chk++;
    if (d !== exp_status() || d[15:8] !== 8'(DEPTH - 1)) begin
      n_fail++; $display("FAIL rx_overrun_status: got %h required %h", d, exp_status());
    end
    while (rxq.size() != 0) begin
      axi_read(13'h000, d, r);
      n_chk++;
      if (d !== {1'b1, 23'd0, rxq[0]}) begin n_fail++; $display("FAIL rx_ovr_drain: got %h required %h", d, {1'b1, 23'd0, rxq[0]}); end
      void'(rxq.pop_front());
    end
    axi_write(13'h00C, 32'h10, 4'hF, r); m_rx_ovr = 1'b0;
    axi_read(13'h008, d, r);
    n_chk++;
    if (d !== exp_status()) begin n_fail++; $display("FAIL rx_ovr_clear: got %h required %h", d, exp_status()); end
  endtask

  task automatic test_regs();
    logic [31:0] d; logic [1:0] r;
    axi_read(13'h100, d, r);
    n_chk++;
    if (d !== 32'h0 || r !== 2'b10) begin n_fail++; $display("FAIL rd_bad_addr: got %h/%b required 0/10", d, r); end
    axi_write(13'h100, 32'hFFFF_FFFF, 4'hF, r);
    n_chk++;
    if (r !== 2'b10) begin n_fail++; $display("FAIL wr_bad_addr: got %b required 10", r); end
    axi_write(13'h008, 32'h1, 4'hF, r);
    n_chk++;
    if (r !== 2'b10) begin n_fail++; $display("FAIL wr_status_ro: got %b required 10", r); end
    axi_read(13'h004, d, r);
    n_chk++;
    if (d !== 32'h0 || r !== 2'b10) begin n_fail++; $display("FAIL rd_txdata_wo: got %h/%b required 0/10", d, r); end
    axi_read(13'h00B, d, r);
    n_chk++;
    if (d !== exp_status() || r !== 2'b00) begin n_fail++; $display("FAIL rd_low_bits: got %h/%b required %h/00", d, r, exp_status()); end
    axi_write(13'h00C, 32'h3, 4'hE, r);
    axi_read(13'h00C, d, r);
    n_chk++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL ctrl_strb0: got %h required 0", d); end
    axi_write(13'h00C, 32'h1F, 4'h1, r);
    axi_read(13'h00C, d, r);
    n_chk++;
    if (d !== 32'h3 || r !== 2'b00) begin n_fail++; $display("FAIL ctrl_readback: got %h/%b required 3/00", d, r); end
    n_chk++;
    if (uart_irq !== 1'b1) begin n_fail++; $display("FAIL txe_irq: got %b required 1", uart_irq); end
    axi_write(13'h00C, 32'h0, 4'hF, r);
    n_chk++;
    if (uart_irq !== 1'b0) begin n_fail++; $display("FAIL irq_disabled: got %b required 0", uart_irq); end
  endtask

  task automatic test_loopback();
    logic [31:0] d; logic [1:0] r;
`ifdef UART_AXIL_LOOPBACK_EN
    axi_write(13'h00C, 32'h20, 4'hF, r);
    tx_ready = 1'b1;
    axi_write(13'h004, 32'h33, 4'hF, r);
    n_chk++;
    if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL lb_tx_valid: got %b required 0", tx_valid); end
    tx_ready = 1'b0;
    axi_read(13'h000, d, r);
    n_chk++;
    if (d !== 32'h8000_0033) begin n_fail++; $display("FAIL lb_rxdata: got %h required 80000033", d); end
    axi_write(13'h00C, 32'h0, 4'hF, r);
`else
    axi_write(13'h00C, 32'h20, 4'hF, r);
    axi_read(13'h00C, d, r);
    n_chk++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL ctrl5_absent: got %h required 0", d); end
    axi_write(13'h004, 32'h33, 4'hF, r);
    n_chk++;
    if ({tx_valid, tx_data} !== 9'h133) begin n_fail++; $display("FAIL no_lb_tx: got %b/%h required 1/33", tx_valid, tx_data); end
    tx_ready = 1'b1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
`endif
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic [1:0] r; bit quiet;
    bus.uart_axi_awaddr = 13'h004; bus.uart_axi_wdata = 32'h77; bus.uart_axi_wstrb = 4'hF;
    bus.uart_axi_awvalid = 1'b1; bus.uart_axi_wvalid = 1'b1;
    @(posedge clk); #1;
    bus.uart_axi_awvalid = 1'b0; bus.uart_axi_wvalid = 1'b0;
    n_chk++;
    if (bus.uart_axi_bvalid !== 1'b1) begin n_fail++; $display("FAIL mid_bvalid: got %b required 1", bus.uart_axi_bvalid); end
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({bus.uart_axi_bvalid, tx_valid} !== 2'b00) begin
      n_fail++; $display("FAIL mid_reset_clear: got %b required 00", {bus.uart_axi_bvalid, tx_valid});
    end
    txq.delete(); rxq.delete(); m_tx_ovf = 1'b0; m_rx_ovr = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (bus.uart_axi_bvalid !== 1'b0 || bus.uart_axi_rvalid !== 1'b0) quiet = 1'b0;
    end
    n_chk++;
    if (!quiet) begin n_fail++; $display("FAIL mid_no_response: bvalid/rvalid %b%b required 00", bus.uart_axi_bvalid, bus.uart_axi_rvalid); end
    axi_read(13'h008, d, r);
    n_chk++;
    if (d !== exp_status()) begin n_fail++; $display("FAIL mid_status: got %h required %h", d, exp_status()); end
  endtask

  initial begin
    bus.uart_axi_awaddr = '0; bus.uart_axi_awvalid = 1'b0; bus.uart_axi_wdata = '0;
    bus.uart_axi_wstrb = '0; bus.uart_axi_wvalid = 1'b0; bus.uart_axi_bready = 1'b0;
    bus.uart_axi_araddr = '0; bus.uart_axi_arvalid = 1'b0; bus.uart_axi_rready = 1'b0;
    tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;
    m_tx_ovf = 1'b0; m_rx_ovr = 1'b0;
    test_reset();
    test_tx_order();
    test_tx_overflow();
    test_rx_irq();
    test_rx_random();
    test_rx_overrun();
    test_regs();
    test_loopback();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/uart_axil_responder.md
Name: uart_axil_responder

Overview:
- AXI4-Lite responder for the chipset UART port (13-bit address, 32-bit data).
- Terminates the uart_axi_* master channels driven from the system and produces uart_irq back to it.
- Holds TX and RX byte FIFOs plus control/status registers.
- Bridges to a byte-stream serializer/deserializer on the far side.

Parameters:
FIFO_DEPTH, 16, entries per TX and RX FIFO; power of 2, >=2
CNT_W, $clog2(FIFO_DEPTH)+1, width of the occupancy counters

Ports:
chipset_clk  in  1  single clock for all logic
chipset_rst_n  in  1  asynchronous active-low reset
uart_axi_awaddr  in  13  write address
uart_axi_awvalid  in  1  AW valid
uart_axi_awready  out  1  AW ready
uart_axi_wdata  in  32  write data
uart_axi_wstrb  in  4  byte strobes
uart_axi_wvalid  in  1  W valid
uart_axi_wready  out  1  W ready
uart_axi_bresp  out  2  write response
uart_axi_bvalid  out  1  B valid
uart_axi_bready  in  1  B ready
uart_axi_araddr  in  13  read address
uart_axi_arvalid  in  1  AR valid
uart_axi_arready  out  1  AR ready
uart_axi_rdata  out  32  read data
uart_axi_rresp  out  2  read response
uart_axi_rvalid  out  1  R valid
uart_axi_rready  in  1  R ready
tx_data  out  8  byte to serializer
tx_valid  out  1  tx_data valid
tx_ready  in  1  serializer accepts byte
rx_data  in  8  byte from deserializer
rx_valid  in  1  one-cycle strobe; no backpressure
uart_irq  out  1  level interrupt, registered

Behaviour:
- Reset: all AXI ready/valid outputs 0, bresp/rresp/rdata 0, tx_valid 0, uart_irq 0, FIFOs empty, CTRL 0, sticky bits 0.
- Decode uses awaddr/araddr[12:2]; bits [1:0] are ignored.
- 0x000 RXDATA (RO): [7:0] popped byte, [31] 1 if a byte was popped. Read while RX FIFO empty returns 0 with no pop and OKAY.
- 0x004 TXDATA (WO): if wstrb[0], wdata[7:0] is pushed. If TX FIFO is full: byte dropped, tx_overflow sticky set, bresp=SLVERR (2'b10). wstrb[0]=0 gives no push and OKAY.
- 0x008 STATUS (RO): [0] rx_nonempty, [1] rx_full, [2] tx_empty, [3] tx_full, [4] tx_overflow, [5] rx_overrun, [15:8] rx count zero-extended, [23:16] tx count. Other bits 0.
- 0x00C CTRL (RW): [0] rx_irq_en, [1] txe_irq_en, [5] loopback (see Optional Feature). These bits are stored only for byte lanes with wstrb set.
- 0x00C CTRL pulses, write-1, self-clearing, read as 0: [2] tx flush, [3] rx flush, [4] clear both sticky bits.
- Any other address: write ignored with SLVERR; read returns 0 with SLVERR. Writes to RO addresses and reads of WO addresses also return SLVERR.
- Write handshake:
  - awready = wready = awvalid & wvalid & ~bvalid, both asserted in the same cycle.
  - Register update and FIFO push happen on that cycle.
  - bvalid rises the next cycle and holds, with bresp stable, until bready.
- Read handshake:
  - arready = ~rvalid.
  - RX pop and data capture happen on AR acceptance.
  - rvalid rises the next cycle and holds, with rdata/rresp stable, until rready.
  - Back-to-back: new AR is accepted only the cycle after the R handshake.
- Read and write channels are independent and may complete in the same cycle.
- TX stream:
  - tx_data/tx_valid are a registered FIFO head; tx_valid = TX FIFO nonempty.
  - Pop on tx_valid & tx_ready.
  - tx_data holds while tx_valid=1 and tx_ready=0.
- RX stream: on rx_valid, push rx_data. If RX FIFO is full, drop the byte and set rx_overrun.
- Full/empty rule: full/empty are evaluated on the pre-cycle state. A push to a full FIFO is rejected even when a pop occurs in the same cycle. Push and pop on a non-full, non-empty FIFO both succeed and the count is unchanged.
- Flush takes priority over a same-cycle push or pop: the FIFO is empty next cycle and the pushed byte is lost without setting a sticky bit. The same priority applies to a sticky clear colliding with a set: clear wins.
- Pointers wrap modulo FIFO_DEPTH; counts run 0..FIFO_DEPTH.
- uart_irq is registered (one cycle after cause): (rx_irq_en & (rx_nonempty | rx_overrun)) | (txe_irq_en & tx_empty).
- Reset asserted mid-transaction: the outstanding B/R is abandoned, all state returns to reset values immediately, and no response is issued after deassertion.

Optional Feature:
UART_AXIL_LOOPBACK_EN
- Defined: CTRL[5] is writable. When 1, the TX FIFO head pops into the RX FIFO internally at one byte per cycle, stalling while the RX FIFO is full (no overrun from loopback). tx_valid is forced to 0 and rx_valid is ignored.
- Not defined: CTRL[5] reads 0, writes to it are ignored, and no loopback logic is present.

Test Plan:
- Reset, then read 0x008 -> rdata=0x00000004 (tx_empty), OKAY; uart_irq=0.
- Write 0x41,0x42 to 0x004 with tx_ready=0, then raise tx_ready -> tx_data 0x41 then 0x42 on consecutive cycles; STATUS[23:16] goes 2->0.
- Write FIFO_DEPTH+1 bytes with tx_ready=0 -> last bresp=SLVERR; STATUS[4]=1; write 0x10 to 0x00C -> STATUS[4]=0.
- Write CTRL=0x1; pulse rx_valid with 0x5A -> uart_irq=1 two cycles later; read 0x000 -> 0x8000005A; uart_irq falls; next read 0x000 -> 0x00000000.
- Fill RX, then rx_valid with a same-cycle AR pop -> byte dropped, STATUS[5]=1, count FIFO_DEPTH-1. Hold rready=0 for 5 cycles -> rvalid/rdata stable, arready=0.
- Read 0x100 -> rresp=2'b10, rdata=0. With UART_AXIL_LOOPBACK_EN: CTRL=0x20, write 0x33 -> RXDATA reads 0x80000033, tx_valid stays 0.
